// File: rtl/wash_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the wash sequencer: state encoding and the helper
// that turns the front-panel cycle request into the number of wash/rinse
// pairs actually run.
// -----------------------------------------------------------------------------
package wash_pkg;

    localparam int STATE_W = 3;

    // Encoding is consumed directly by the motor/valve decode logic, so the
    // numeric values are fixed. Value 7 is unused and treated as illegal.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        SOAK  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        PAUSE = 3'd5,
        DONE  = 3'd6
    } state_t;

    // A request of zero still runs one pair; requests above the supported
    // maximum are clamped to that maximum.
    function automatic int unsigned clamp_cycles(input int unsigned requested,
                                                 input int unsigned max_cycles);
        if (requested == 0)
            return 1;
        else if (requested > max_cycles)
            return max_cycles;
        else
            return requested;
    endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// -----------------------------------------------------------------------------
// wash_sequencer_if
// Front-panel inputs and status outputs of the wash sequencer.
//   coin, start, cycles, lid, abort : panel -> sequencer
//   state, phase_left, cycle_idx,
//   credit, busy, door_lock, done   : sequencer -> decode logic / panel
// master : the side driving the panel inputs
// slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface wash_sequencer_if #(
    parameter int CNT_W    = 2,
    parameter int TIMER_W  = 8,
    parameter int CREDIT_W = 2
);
    logic                coin;
    logic                start;
    logic [CNT_W-1:0]    cycles;
    logic                lid;
    logic                abort;
    logic [2:0]          state;
    logic [TIMER_W-1:0]  phase_left;
    logic [CNT_W-1:0]    cycle_idx;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                door_lock;
    logic                done;

    modport master (
        output coin, start, cycles, lid, abort,
        input  state, phase_left, cycle_idx, credit, busy, door_lock, done
    );

    modport slave (
        input  coin, start, cycles, lid, abort,
        output state, phase_left, cycle_idx, credit, busy, door_lock, done
    );
endinterface

// File: rtl/wash_sequencer_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Down-counter shared by every running phase.
//   clock, reset : clock and asynchronous active-low reset
//   load/load_val: load a new value (takes priority over en)
//   en           : decrement by one; holding en low freezes the count
//   count        : current value, zero : count == 0
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int TIMER_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    // Load wins over decrement so a phase change never loses its new duration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wash_sequencer.sv
// -----------------------------------------------------------------------------
// wash_sequencer
// Wash-cycle controller: coin credit, SOAK -> (WASH -> RINSE) x n -> SPIN ->
// DONE, with a lid interlock that pauses and resumes the running phase and
// an abort path straight to SPIN.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : panel inputs (coin, start, cycles, lid, abort) and registered
//           status outputs (state, phase_left, cycle_idx, credit, busy,
//           door_lock, done)
// -----------------------------------------------------------------------------
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TIMER_W    = 8,
    parameter int SOAK_T     = 20,
    parameter int WASH_T     = 30,
    parameter int RINSE_T    = 20,
    parameter int SPIN_T     = 15,
    parameter int CNT_W      = 2,
    parameter int MAX_CYCLES = 3,
    parameter int PRICE      = 2
) (
    input  logic             clock,
    input  logic             reset,
    wash_sequencer_if.slave  bus
);

    localparam int CREDIT_W = $clog2(PRICE + 1);

    localparam logic [TIMER_W-1:0]  SOAK_V  = TIMER_W'(SOAK_T - 1);
    localparam logic [TIMER_W-1:0]  WASH_V  = TIMER_W'(WASH_T - 1);
    localparam logic [TIMER_W-1:0]  RINSE_V = TIMER_W'(RINSE_T - 1);
    localparam logic [TIMER_W-1:0]  SPIN_V  = TIMER_W'(SPIN_T - 1);
    localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);

    state_t              state_q, state_d;
    state_t              resume_q, resume_d;
    logic [TIMER_W-1:0]  saved_q, saved_d;
    logic [CNT_W-1:0]    ncyc_q, ncyc_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                busy_q, busy_d;
    logic                lock_q, lock_d;
    logic                done_q, done_d;

    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_val;
    logic                tmr_en;
    logic [TIMER_W-1:0]  tmr_count;
    logic                tmr_zero;

    logic [CNT_W:0]      idx_plus_one;
    logic                more_pairs;

    phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // One extra bit so the comparison cannot wrap when idx is at its maximum.
    assign idx_plus_one = {1'b0, idx_q} + (CNT_W+1)'(1);
    assign more_pairs   = (idx_plus_one < {1'b0, ncyc_q});

    // State register together with every registered output, so all status
    // outputs change on the same edge as the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            resume_q <= IDLE;
            saved_q  <= '0;
            ncyc_q   <= '0;
            idx_q    <= '0;
            credit_q <= '0;
            busy_q   <= 1'b0;
            lock_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            saved_q  <= saved_d;
            ncyc_q   <= ncyc_d;
            idx_q    <= idx_d;
            credit_q <= credit_d;
            busy_q   <= busy_d;
            lock_q   <= lock_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath control. Priority inside a running phase is
    // lid, then abort, then expiry; the timer only counts when none fires.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        saved_d  = saved_q;
        ncyc_d   = ncyc_q;
        idx_d    = idx_q;
        credit_d = credit_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (credit_q == PRICE_V && bus.start && !bus.lid) begin
                    state_d  = SOAK;
                    credit_d = '0;
                    ncyc_d   = CNT_W'(clamp_cycles(32'(bus.cycles), MAX_CYCLES));
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = SOAK_V;
                end else if (bus.coin && credit_q != PRICE_V) begin
                    credit_d = credit_q + 1'b1;
                end
            end

            SOAK, WASH, RINSE, SPIN: begin
                if (bus.lid) begin
                    state_d  = PAUSE;
                    resume_d = state_q;
                    saved_d  = tmr_count;
                end else if (bus.abort && state_q != SPIN) begin
                    state_d  = SPIN;
                    tmr_load = 1'b1;
                    tmr_val  = SPIN_V;
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    case (state_q)
                        SOAK: begin
                            state_d = WASH;
                            tmr_val = WASH_V;
                        end
                        WASH: begin
                            state_d = RINSE;
                            tmr_val = RINSE_V;
                        end
                        RINSE: begin
                            if (more_pairs) begin
                                state_d = WASH;
                                idx_d   = idx_plus_one[CNT_W-1:0];
                                tmr_val = WASH_V;
                            end else begin
                                state_d = SPIN;
                                tmr_val = SPIN_V;
                            end
                        end
                        default: begin
                            state_d  = DONE;
                            tmr_load = 1'b0;
                        end
                    endcase
                end else begin
                    tmr_en = 1'b1;
                end
            end

            // Abort while paused redirects the resume to a full SPIN, even
            // with the lid still open; closing the lid on the same edge as
            // the abort goes straight there.
            PAUSE: begin
                if (!bus.lid) begin
                    tmr_load = 1'b1;
                    if (bus.abort) begin
                        state_d = SPIN;
                        tmr_val = SPIN_V;
                    end else begin
                        state_d = resume_q;
                        tmr_val = saved_q;
                    end
                end else if (bus.abort) begin
                    resume_d = SPIN;
                    saved_d  = SPIN_V;
                end
            end

            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Status outputs derived from the upcoming state and registered above.
    always_comb begin
        busy_d = (state_d != IDLE);
        lock_d = (state_d inside {SOAK, WASH, RINSE, SPIN});
        done_d = (state_d == DONE);
    end

    assign bus.state      = state_q;
    assign bus.phase_left = tmr_count;
    assign bus.cycle_idx  = idx_q;
    assign bus.credit     = credit_q;
    assign bus.busy       = busy_q;
    assign bus.door_lock  = lock_q;
    assign bus.done       = done_q;

endmodule
